// File: rtl/uart_cmd_ctl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctl
// Host-facing UART command front-end of the plasma simulator. It receives
// ASCII commands on an 8N1 serial line ("*<letter><hex digits>"), parses the
// hex field and drives the compute core's particle-load, B-field, run-start
// and grid-readback interfaces. Grid read results are returned as ASCII.
//
// Ports:
//   sys_clk, usr_rst     system clock, asynchronous active-low reset
//   rxd_i / txd_o        UART receive / transmit lines (idle high)
//   p_wr_en/addr/data    particle RAM write (address auto-increments)
//   bmag_wr, bmag        magnetic-field magnitude register + update strobe
//   go, num_iters, busy  run-start strobe, iteration count, core busy flag
//   grid_rd_*            grid readback request / response handshake
// ---------------------------------------------------------------------------
module uart_cmd_ctl #(
  parameter int CLK_FREQ  = 200_000_000,
  parameter int BAUD_RATE = 9_600,
  parameter int PADDR_W   = 10
) (
  input  logic               sys_clk,
  input  logic               usr_rst,
  input  logic               rxd_i,
  output logic               txd_o,
  output logic               p_wr_en,
  output logic [PADDR_W-1:0] p_wr_addr,
  output logic [51:0]        p_wr_data,
  output logic               bmag_wr,
  output logic [27:0]        bmag,
  output logic               go,
  output logic [31:0]        num_iters,
  input  logic               busy,
  output logic               grid_rd_en,
  output logic               grid_rd_sel,
  output logic [11:0]        grid_rd_addr,
  input  logic [31:0]        grid_rd_data,
  input  logic               grid_rd_valid
);

  localparam int DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_P    = 8'h70;
  localparam logic [7:0] CH_M    = 8'h6D;
  localparam logic [7:0] CH_G    = 8'h67;
  localparam logic [7:0] CH_C    = 8'h63;
  localparam logic [7:0] CH_E    = 8'h65;
  localparam logic [7:0] CH_LF   = 8'h0A;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_CMD, P_HEX, P_EXEC, P_WAIT_RD, P_RESP} p_state_t;

  // Receiver state
  logic [2:0]    rx_sync_q;
  rx_state_t     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_valid_q;
  logic [7:0]    rx_byte_q;

  // Transmitter state
  tx_state_t     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          txd_q;
  logic          tx_busy;

  // Parser state and registered outputs
  p_state_t           p_state_q;
  logic [7:0]         cmd_q;
  logic [3:0]         need_q;
  logic [3:0]         digits_q;
  logic [51:0]        field_q;
  logic [31:0]        rdata_q;
  logic [3:0]         resp_idx_q;
  logic               tx_start_q;
  logic [7:0]         tx_byte_q;
  logic               p_wr_en_q;
  logic [PADDR_W-1:0] p_wr_addr_q;
  logic [51:0]        p_wr_data_q;
  logic               bmag_wr_q;
  logic [27:0]        bmag_q;
  logic               go_q;
  logic [31:0]        num_iters_q;
  logic               grid_rd_en_q;
  logic               grid_rd_sel_q;
  logic [11:0]        grid_rd_addr_q;

  logic       hex_vld;
  logic [3:0] hex_nib;
  logic [2:0] nib_sel;
  logic [3:0] resp_nib;
  logic [7:0] resp_byte;

  // rx_sync_q[1] is the synchronized line, rx_sync_q[2] its previous value,
  // so a 1->0 step between them marks a candidate start bit.
  always_ff @(posedge sys_clk or negedge usr_rst) begin
    if (!usr_rst) begin
      rx_sync_q  <= 3'b111;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[1:0], rxd_i};
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (rx_sync_q[2] && !rx_sync_q[1]) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q[1] ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == DIV_M1) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q[1], rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == DIV_M1) begin
            // A low stop bit is a framing error: the byte is dropped.
            if (rx_sync_q[1]) begin
              rx_valid_q <= 1'b1;
              rx_byte_q  <= rx_shift_q;
            end
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign tx_busy = (tx_state_q != TX_IDLE);

  // 8N1 transmitter; a byte is only taken from tx_byte_q while idle.
  always_ff @(posedge sys_clk or negedge usr_rst) begin
    if (!usr_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          txd_q    <= 1'b1;
          tx_cnt_q <= '0;
          if (tx_start_q) begin
            tx_shift_q <= tx_byte_q;
            txd_q      <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START, TX_DATA: begin
          if (tx_cnt_q == DIV_M1) begin
            tx_cnt_q <= '0;
            if (tx_state_q == TX_DATA && tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= (tx_state_q == TX_START) ? 3'd0 : tx_bit_q + 1'b1;
              tx_state_q <= TX_DATA;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == DIV_M1) tx_state_q <= TX_IDLE;
          else                    tx_cnt_q   <= tx_cnt_q + 1'b1;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // Hex digit decode; upper and lower case letters share the low nibble.
  always_comb begin
    hex_vld = 1'b1;
    hex_nib = rx_byte_q[3:0];
    if (rx_byte_q >= 8'h30 && rx_byte_q <= 8'h39) begin
      hex_nib = rx_byte_q[3:0];
    end else if ((rx_byte_q >= 8'h61 && rx_byte_q <= 8'h66) ||
                 (rx_byte_q >= 8'h41 && rx_byte_q <= 8'h46)) begin
      hex_nib = rx_byte_q[3:0] + 4'd9;
    end else begin
      hex_vld = 1'b0;
    end
  end

  // Response byte: '*', letter, 8 lowercase hex digits MSB first, LF.
  always_comb begin
    nib_sel  = 3'(4'd9 - resp_idx_q);
    resp_nib = rdata_q[{nib_sel, 2'b00} +: 4];
    case (resp_idx_q)
      4'd0:    resp_byte = CH_STAR;
      4'd1:    resp_byte = cmd_q;
      4'd10:   resp_byte = CH_LF;
      default: resp_byte = (resp_nib < 4'd10) ? {4'h3, resp_nib} : 8'h57 + {4'h0, resp_nib};
    endcase
  end

  // Command parser. Strobes default low so each lasts exactly one cycle;
  // the particle address advances in the cycle after its write strobe.
  always_ff @(posedge sys_clk or negedge usr_rst) begin
    if (!usr_rst) begin
      p_state_q      <= P_IDLE;
      cmd_q          <= '0;
      need_q         <= '0;
      digits_q       <= '0;
      field_q        <= '0;
      rdata_q        <= '0;
      resp_idx_q     <= '0;
      tx_start_q     <= 1'b0;
      tx_byte_q      <= '0;
      p_wr_en_q      <= 1'b0;
      p_wr_addr_q    <= '0;
      p_wr_data_q    <= '0;
      bmag_wr_q      <= 1'b0;
      bmag_q         <= '0;
      go_q           <= 1'b0;
      num_iters_q    <= '0;
      grid_rd_en_q   <= 1'b0;
      grid_rd_sel_q  <= 1'b0;
      grid_rd_addr_q <= '0;
    end else begin
      p_wr_en_q    <= 1'b0;
      bmag_wr_q    <= 1'b0;
      go_q         <= 1'b0;
      grid_rd_en_q <= 1'b0;
      tx_start_q   <= 1'b0;
      if (p_wr_en_q) p_wr_addr_q <= p_wr_addr_q + 1'b1;
      case (p_state_q)
        P_IDLE: begin
          if (rx_valid_q && rx_byte_q == CH_STAR) p_state_q <= P_CMD;
        end
        P_CMD: begin
          if (rx_valid_q && rx_byte_q != CH_STAR) begin
            cmd_q     <= rx_byte_q;
            field_q   <= '0;
            digits_q  <= '0;
            p_state_q <= P_HEX;
            case (rx_byte_q)
              CH_P:       need_q <= 4'd13;
              CH_M:       need_q <= 4'd7;
              CH_G:       need_q <= 4'd8;
              CH_C, CH_E: need_q <= 4'd3;
              default:    p_state_q <= P_IDLE;
            endcase
          end
        end
        P_HEX: begin
          if (rx_valid_q) begin
            if (rx_byte_q == CH_STAR) begin
              p_state_q <= P_CMD;
            end else if (hex_vld) begin
              field_q  <= {field_q[47:0], hex_nib};
              digits_q <= digits_q + 1'b1;
              if (digits_q + 4'd1 == need_q) p_state_q <= P_EXEC;
            end else begin
              p_state_q <= P_IDLE;
            end
          end
        end
        P_EXEC: begin
          p_state_q <= P_IDLE;
          case (cmd_q)
            CH_P: begin
              p_wr_data_q <= field_q;
              p_wr_en_q   <= 1'b1;
            end
            CH_M: begin
              bmag_q    <= field_q[27:0];
              bmag_wr_q <= 1'b1;
            end
            CH_G: begin
              if (!busy) begin
                num_iters_q <= field_q[31:0];
                go_q        <= 1'b1;
              end
            end
            CH_C, CH_E: begin
              grid_rd_addr_q <= field_q[11:0];
              grid_rd_sel_q  <= (cmd_q == CH_E);
              grid_rd_en_q   <= 1'b1;
              p_state_q      <= P_WAIT_RD;
            end
            default: p_state_q <= P_IDLE;
          endcase
        end
        P_WAIT_RD: begin
          if (grid_rd_valid) begin
            rdata_q    <= grid_rd_data;
            resp_idx_q <= '0;
            p_state_q  <= P_RESP;
          end
        end
        P_RESP: begin
          // tx_start_q is checked too because tx_busy rises one cycle late.
          if (!tx_busy && !tx_start_q) begin
            if (resp_idx_q == 4'd11) begin
              p_state_q <= P_IDLE;
            end else begin
              tx_start_q <= 1'b1;
              tx_byte_q  <= resp_byte;
              resp_idx_q <= resp_idx_q + 1'b1;
            end
          end
        end
        default: p_state_q <= P_IDLE;
      endcase
    end
  end

  assign txd_o        = txd_q;
  assign p_wr_en      = p_wr_en_q;
  assign p_wr_addr    = p_wr_addr_q;
  assign p_wr_data    = p_wr_data_q;
  assign bmag_wr      = bmag_wr_q;
  assign bmag         = bmag_q;
  assign go           = go_q;
  assign num_iters    = num_iters_q;
  assign grid_rd_en   = grid_rd_en_q;
  assign grid_rd_sel  = grid_rd_sel_q;
  assign grid_rd_addr = grid_rd_addr_q;

endmodule

// File: tb/tb_uart_cmd_ctl.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctl
// Testbench for uart_cmd_ctl. The UART runs at 16 clocks per bit so whole
// command frames fit in a short run. Single-cycle commands are driven from a
// table of frames with hand-computed expected outputs; grid reads, the
// response path and mid-response reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctl;

  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int PA       = 10;
  localparam int DIV      = 16;

  logic          sys_clk = 1'b0;
  logic          usr_rst = 1'b1;
  logic          rxd_i = 1'b1;
  logic          busy = 1'b0;
  logic [31:0]   grid_rd_data = '0;
  logic          grid_rd_valid = 1'b0;
  logic          txd_o;
  logic          p_wr_en;
  logic [PA-1:0] p_wr_addr;
  logic [51:0]   p_wr_data;
  logic          bmag_wr;
  logic [27:0]   bmag;
  logic          go;
  logic [31:0]   num_iters;
  logic          grid_rd_en;
  logic          grid_rd_sel;
  logic [11:0]   grid_rd_addr;

  uart_cmd_ctl #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD),
    .PADDR_W  (PA)
  ) dut (
    .sys_clk      (sys_clk),
    .usr_rst      (usr_rst),
    .rxd_i        (rxd_i),
    .txd_o        (txd_o),
    .p_wr_en      (p_wr_en),
    .p_wr_addr    (p_wr_addr),
    .p_wr_data    (p_wr_data),
    .bmag_wr      (bmag_wr),
    .bmag         (bmag),
    .go           (go),
    .num_iters    (num_iters),
    .busy         (busy),
    .grid_rd_en   (grid_rd_en),
    .grid_rd_sel  (grid_rd_sel),
    .grid_rd_addr (grid_rd_addr),
    .grid_rd_data (grid_rd_data),
    .grid_rd_valid(grid_rd_valid)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         frame;
    logic          busyIn;
    int            badAt;
    int            expPwr;
    int            expBmw;
    int            expGo;
    logic [27:0]   expBmag;
    logic [31:0]   expIters;
    logic [PA-1:0] expAddr;
    logic [PA-1:0] expLastAddr;
    logic [51:0]   expLastData;
  } vec_t;

  vec_t vecs[10];

  // Strobe monitor: counts pulses, captures payloads, flags any strobe
  // that stays high for two consecutive cycles.
  int            pWrCount = 0;
  int            bmagWrCount = 0;
  int            goCount = 0;
  int            rdEnCount = 0;
  int            longStrobes = 0;
  logic [PA-1:0] lastPAddr = '0;
  logic [51:0]   lastPData = '0;
  logic [11:0]   lastRdAddr = '0;
  logic          lastRdSel = 1'b0;
  logic [3:0]    prevStb = '0;

  always @(negedge sys_clk) begin
    if (p_wr_en === 1'b1) begin
      pWrCount++;
      lastPAddr = p_wr_addr;
      lastPData = p_wr_data;
    end
    if (bmag_wr === 1'b1) bmagWrCount++;
    if (go === 1'b1) goCount++;
    if (grid_rd_en === 1'b1) begin
      rdEnCount++;
      lastRdAddr = grid_rd_addr;
      lastRdSel  = grid_rd_sel;
    end
    if (({p_wr_en, bmag_wr, go, grid_rd_en} & prevStb) != 4'b0) longStrobes++;
    prevStb = {p_wr_en, bmag_wr, go, grid_rd_en};
  end

  // Serial decoder for txd_o: samples each bit at its centre.
  logic [7:0] txBytes[$];
  int         txFrameErr = 0;

  initial begin : txDecoder
    logic [7:0] b;
    forever begin
      @(negedge sys_clk);
      if (txd_o === 1'b0) begin
        repeat (DIV / 2) @(negedge sys_clk);
        if (txd_o === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge sys_clk);
            b[i] = txd_o;
          end
          repeat (DIV) @(negedge sys_clk);
          if (txd_o !== 1'b1) txFrameErr++;
          txBytes.push_back(b);
        end
      end
    end
  end

  // Grid memory model: answers two cycles after each read request.
  logic [31:0] modelData = '0;

  initial begin : gridModel
    forever begin
      @(negedge sys_clk);
      if (grid_rd_en === 1'b1) begin
        @(negedge sys_clk);
        @(negedge sys_clk);
        grid_rd_data  = modelData;
        grid_rd_valid = 1'b1;
        @(negedge sys_clk);
        grid_rd_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rxd_i = 1'b0;
    repeat (DIV) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      repeat (DIV) @(negedge sys_clk);
    end
    rxd_i = stopBit;
    repeat (DIV) @(negedge sys_clk);
    if (!stopBit) begin
      rxd_i = 1'b1;
      repeat (DIV) @(negedge sys_clk);
    end
  endtask

  // Sends a string; a garbage byte with a low stop bit goes in front of
  // character index badAt (-1 for none).
  task automatic applyStimulus(input string s, input int badAt);
    for (int i = 0; i < s.len(); i++) begin
      if (i == badAt) sendByte(8'h5A, 1'b0);
      sendByte(s[i], 1'b1);
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic checkRead(input string tag, input int base, input int rdBase, input int errBase,
                           input string expStr, input logic expSel, input logic [11:0] expAddr);
    logic [7:0] expB;
    for (int c = 0; c < 6000 && txBytes.size() < base + 11; c++) @(negedge sys_clk);
    checkOutput({tag, " txCount"}, 64'(txBytes.size() - base), 64'd11);
    if (txBytes.size() >= base + 11) begin
      for (int k = 0; k < 11; k++) begin
        expB = (k < 10) ? expStr[k] : 8'h0A;
        checkOutput($sformatf("%s tx[%0d]", tag, k), 64'(txBytes[base + k]), 64'(expB));
      end
    end
    repeat (DIV) @(negedge sys_clk);
    checkOutput({tag, " txIdle"}, 64'(txd_o), 64'd1);
    checkOutput({tag, " framing"}, 64'(txFrameErr - errBase), 64'd0);
    checkOutput({tag, " rdEnPulses"}, 64'(rdEnCount - rdBase), 64'd1);
    checkOutput({tag, " rdSel@en"}, 64'(lastRdSel), 64'(expSel));
    checkOutput({tag, " rdAddr@en"}, 64'(lastRdAddr), 64'(expAddr));
    checkOutput({tag, " rdSelHold"}, 64'(grid_rd_sel), 64'(expSel));
    checkOutput({tag, " rdAddrHold"}, 64'(grid_rd_addr), 64'(expAddr));
  endtask

  function automatic vec_t mkVec(input string f, input logic bz, input int bad, input int pw,
                                 input int bw, input int g, input logic [27:0] bm,
                                 input logic [31:0] it, input logic [PA-1:0] ad,
                                 input logic [PA-1:0] la, input logic [51:0] ld);
    vec_t v;
    v.frame = f;   v.busyIn = bz;  v.badAt = bad;
    v.expPwr = pw; v.expBmw = bw;  v.expGo = g;
    v.expBmag = bm; v.expIters = it; v.expAddr = ad;
    v.expLastAddr = la; v.expLastData = ld;
    return v;
  endfunction

  initial begin : main
    int  pBase, bBase, gBase, tBase, rBase, eBase;
    bit  seenLow;

    vecs[0] = mkVec("*p4000200002000", 0, -1, 1, 0, 0, 28'h0,       32'h0, 10'd1, 10'd0, 52'h4000200002000);
    vecs[1] = mkVec("*p2000100002800", 0, -1, 1, 0, 0, 28'h0,       32'h0, 10'd2, 10'd1, 52'h2000100002800);
    vecs[2] = mkVec("*m000ffff",       0, -1, 0, 1, 0, 28'h000ffff, 32'h0, 10'd2, 10'd0, 52'h0);
    vecs[3] = mkVec("*m12*m0000001",   0, -1, 0, 1, 0, 28'h0000001, 32'h0, 10'd2, 10'd0, 52'h0);
    vecs[4] = mkVec("*g00000004",      0, -1, 0, 0, 1, 28'h0000001, 32'h4, 10'd2, 10'd0, 52'h0);
    vecs[5] = mkVec("*g00000009",      1, -1, 0, 0, 0, 28'h0000001, 32'h4, 10'd2, 10'd0, 52'h0);
    vecs[6] = mkVec("*pZZ",            0, -1, 0, 0, 0, 28'h0000001, 32'h4, 10'd2, 10'd0, 52'h0);
    vecs[7] = mkVec("*x123",           0, -1, 0, 0, 0, 28'h0000001, 32'h4, 10'd2, 10'd0, 52'h0);
    vecs[8] = mkVec("*m0000abc",       0,  4, 0, 1, 0, 28'h0000abc, 32'h4, 10'd2, 10'd0, 52'h0);
    vecs[9] = mkVec("*mFeDcBa9",       0, -1, 0, 1, 0, 28'hfedcba9, 32'h4, 10'd2, 10'd0, 52'h0);

    // Reset values
    #2 usr_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    checkOutput("reset txd_o", 64'(txd_o), 64'd1);
    checkOutput("reset strobes", 64'({p_wr_en, bmag_wr, go, grid_rd_en}), 64'd0);
    checkOutput("reset bmag", 64'(bmag), 64'd0);
    checkOutput("reset num_iters", 64'(num_iters), 64'd0);
    checkOutput("reset p_wr_addr", 64'(p_wr_addr), 64'd0);
    usr_rst = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Table-driven single-cycle commands
    for (int i = 0; i < 10; i++) begin
      pBase = pWrCount; bBase = bmagWrCount; gBase = goCount; tBase = txBytes.size();
      busy = vecs[i].busyIn;
      applyStimulus(vecs[i].frame, vecs[i].badAt);
      checkOutput($sformatf("v%0d pWrPulses", i), 64'(pWrCount - pBase), 64'(vecs[i].expPwr));
      checkOutput($sformatf("v%0d bmagWrPulses", i), 64'(bmagWrCount - bBase), 64'(vecs[i].expBmw));
      checkOutput($sformatf("v%0d goPulses", i), 64'(goCount - gBase), 64'(vecs[i].expGo));
      checkOutput($sformatf("v%0d bmag", i), 64'(bmag), 64'(vecs[i].expBmag));
      checkOutput($sformatf("v%0d num_iters", i), 64'(num_iters), 64'(vecs[i].expIters));
      checkOutput($sformatf("v%0d p_wr_addr", i), 64'(p_wr_addr), 64'(vecs[i].expAddr));
      checkOutput($sformatf("v%0d txQuiet", i), 64'(txBytes.size() - tBase), 64'd0);
      checkOutput($sformatf("v%0d txd_o", i), 64'(txd_o), 64'd1);
      if (vecs[i].expPwr > 0) begin
        checkOutput($sformatf("v%0d pAddr@en", i), 64'(lastPAddr), 64'(vecs[i].expLastAddr));
        checkOutput($sformatf("v%0d pData@en", i), 64'(lastPData), 64'(vecs[i].expLastData));
      end
    end
    busy = 1'b0;

    // Charge read
    modelData = 32'h0000_1234;
    tBase = txBytes.size(); rBase = rdEnCount; eBase = txFrameErr;
    applyStimulus("*c202", -1);
    checkRead("readC", tBase, rBase, eBase, "*c00001234", 1'b0, 12'h202);

    // Phi read with traffic on RX while the response is going out
    modelData = 32'hDEAD_BEEF;
    tBase = txBytes.size(); rBase = rdEnCount; eBase = txFrameErr; bBase = bmagWrCount;
    applyStimulus("*e202", -1);
    applyStimulus("*m1234567", -1);
    checkRead("readE", tBase, rBase, eBase, "*edeadbeef", 1'b1, 12'h202);
    checkOutput("readE ignoredRx bmagWr", 64'(bmagWrCount - bBase), 64'd0);
    checkOutput("readE ignoredRx bmag", 64'(bmag), 64'(28'hfedcba9));

    // Reset in the middle of a response byte
    modelData = 32'h0BAD_F00D;
    tBase = txBytes.size();
    applyStimulus("*c0ff", -1);
    for (int c = 0; c < 4000 && txBytes.size() < tBase + 2; c++) @(negedge sys_clk);
    seenLow = 1'b0;
    for (int c = 0; c < 400 && !seenLow; c++) begin
      @(negedge sys_clk);
      if (txd_o === 1'b0) seenLow = 1'b1;
    end
    checkOutput("rst responseActive", 64'(seenLow), 64'd1);
    usr_rst = 1'b0;
    #1;
    checkOutput("rst txd_o", 64'(txd_o), 64'd1);
    checkOutput("rst bmag", 64'(bmag), 64'd0);
    checkOutput("rst num_iters", 64'(num_iters), 64'd0);
    checkOutput("rst p_wr_addr", 64'(p_wr_addr), 64'd0);
    repeat (3) @(negedge sys_clk);
    usr_rst = 1'b1;
    repeat (12 * DIV) @(negedge sys_clk);
    checkOutput("rst txQuiet", 64'(txd_o), 64'd1);

    // Recovery after reset: address counter restarts from zero
    pBase = pWrCount;
    applyStimulus("*p0000000000001", -1);
    checkOutput("post pWrPulses", 64'(pWrCount - pBase), 64'd1);
    checkOutput("post pAddr@en", 64'(lastPAddr), 64'd0);
    checkOutput("post pData@en", 64'(lastPData), 64'd1);
    checkOutput("post p_wr_addr", 64'(p_wr_addr), 64'd1);
    applyStimulus("*m0000abc", -1);
    checkOutput("post bmag", 64'(bmag), 64'(28'h0000abc));

    checkOutput("strobe width", 64'(longStrobes), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctl.md
Name: uart_cmd_ctl

Overview:
- Host-facing UART command front-end of the plasma simulator.
- Receives ASCII commands on an 8N1 serial line and parses hex fields.
- Drives the particle-load, B-field, run-start and grid-readback interfaces of the compute core.
- Returns grid read results as ASCII over the TX line.

Parameters:
CLK_FREQ, 200_000_000, system clock frequency in Hz.
BAUD_RATE, 9_600, serial bit rate; overridable per instance.
PADDR_W, 10, particle RAM address width.

Ports:
sys_clk  in  1  system clock.
usr_rst  in  1  asynchronous active-low reset.
rxd_i  in  1  UART receive line, idle high.
txd_o  out  1  UART transmit line, idle high.
p_wr_en  out  1  one-cycle particle write strobe.
p_wr_addr  out  PADDR_W  particle write address.
p_wr_data  out  52  particle record: x[51:36], y[35:20], mu[19:16], vpar[15:0].
bmag_wr  out  1  one-cycle strobe when bmag updates.
bmag  out  28  magnetic-field magnitude register.
go  out  1  one-cycle run-start strobe.
num_iters  out  32  iteration count latched on go.
busy  in  1  core is running.
grid_rd_en  out  1  one-cycle grid read request.
grid_rd_sel  out  1  0 = charge, 1 = phi.
grid_rd_addr  out  12  grid cell address.
grid_rd_data  in  32  read data.
grid_rd_valid  in  1  read data valid (any latency ≥1).

Behaviour:
Reset state (usr_rst low):
- txd_o=1; all strobes 0; bmag=0; num_iters=0; p_wr_addr=0.
- Parser in IDLE; TX idle.

UART RX:
- 2-flop synchronizer on rxd_i.
- Divisor = round(CLK_FREQ/BAUD_RATE).
- Start bit detected on falling edge and confirmed at half-bit.
- Data sampled at bit centres, LSB first.
- If the stop bit samples 0, the byte is discarded.

UART TX:
- Same divisor; 8N1, LSB first.
- Accepts a byte only when idle.

Parser states:
- IDLE: waits for '*'.
- CMD: expects a command letter.
- HEX: collects N hex digits, MSB first.
- EXEC: issues the command.
- WAIT_RD: waits for read data.
- RESP: transmits the response.

Parser rules:
- '*' received in any state except RESP/WAIT_RD restarts at CMD, discarding the partial field.
- Hex digits accepted: 0-9, a-f, A-F.
- Any other character in HEX → IDLE, no action.
- An unknown letter in CMD → IDLE.

Commands (letter, digit count, action in EXEC, one cycle):
- 'p', 13: p_wr_data = field, p_wr_en pulse at p_wr_addr. The following cycle p_wr_addr increments, wrapping at 2^PADDR_W.
- 'm', 7: bmag = field[27:0]; bmag_wr pulse.
- 'g', 8: if busy=0, num_iters = field and go pulses; if busy=1 the command is ignored.
- 'c', 3 / 'e', 3: grid_rd_addr = field, grid_rd_sel = 0 / 1, grid_rd_en pulse → WAIT_RD.

Read response:
- In WAIT_RD, the first grid_rd_valid latches grid_rd_data → RESP.
- RESP transmits 11 bytes: '*', the command letter, 8 lowercase hex digits MSB first, LF (0x0A).
- Then return to IDLE.
- Bytes received during WAIT_RD/RESP are dropped; RX keeps running.

Output holds:
- bmag, num_iters, grid_rd_addr and grid_rd_sel hold their values until the next matching command.
- Strobes are exactly one cycle long.

Mid-operation reset:
- Asserting reset mid-frame or mid-response aborts immediately.
- txd_o returns high within one cycle.

Test Plan:
1. Send "*p4000200002000" then "*p2000100002800".
   - Required: two p_wr_en pulses.
   - Addr 0: data 0x4000_2000_0_2000.
   - Addr 1: data 0x2000_1000_0_2800.
   - p_wr_addr ends at 2.
2. Send "*m000ffff".
   - Required: bmag=0x000FFFF with one bmag_wr pulse.
   - Then send "*m12" followed by "*m0000001": the partial frame is discarded and bmag=0x0000001.
3. Send "*g00000004" with busy=0.
   - Required: one go pulse, num_iters=4.
   - Repeat with busy=1 and "*g00000009": no go pulse, num_iters stays 4.
4. Send "*c202"; model returns 0x0000_1234 two cycles after grid_rd_en.
   - Required: grid_rd_sel=0, grid_rd_addr=0x202.
   - TX bytes: "*c00001234" followed by LF, each byte decodes 8N1 at BAUD_RATE.
5. Send "*e202"; model returns 0xDEADBEEF.
   - Required: grid_rd_sel=1.
   - TX bytes: "*edeadbeef" followed by LF.
   - Characters sent during the response are ignored.
6. Send "*pZZ", a byte with stop bit 0, and "*x123".
   - Required: no strobes, txd_o stays high, parser back in IDLE.
   - A following "*m0000abc" sets bmag=0xABC.
